// File: rtl/multirate_deser_queue.sv
// multirate_deser_queue: fast-rate serial deserializer feeding a slow-rate circular FIFO.
// Define MRDQ_PARITY_EN to receive an even-parity bit per word and flag mismatches.
module multirate_deser_queue #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int FAST_DIV = 5,
  parameter int SLOW_DIV = 50
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  output logic                       status_out,
  output logic                       data_ready,
  input  logic                       enqueue_in,
  input  logic                       dequeue_in,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
`ifdef MRDQ_PARITY_EN
  output logic                       parity_err_out,
`endif
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_W+1);
  localparam int FW = $clog2(FAST_DIV);
  localparam int SW = $clog2(SLOW_DIV);

  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV-1);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_DIV-1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH-1);
  localparam logic [LW-1:0] LEN_FULL  = LW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W-1);

  typedef enum logic [1:0] {
    RECV,
    PAR,
    DONE
  } state_t;

  logic [FW-1:0] fast_cnt;
  logic [SW-1:0] slow_cnt;
  logic          fast_tick;
  logic          slow_tick;

  state_t            state;
  logic [DATA_W-1:0] word;
  logic [BW-1:0]     bit_cnt;
  logic              ack;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              push;
  logic              pop;
  logic [LW-1:0]     len_next;

  assign fast_tick = (fast_cnt == FAST_LAST);
  assign slow_tick = (slow_cnt == SLOW_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fast_cnt <= '0;
      slow_cnt <= '0;
    end else begin
      fast_cnt <= fast_tick ? '0 : fast_cnt + 1'b1;
      slow_cnt <= slow_tick ? '0 : slow_cnt + 1'b1;
    end
  end

  // A pop frees a slot on the same tick, so a full queue still accepts
  assign pop  = slow_tick & dequeue_in & ~empty_out;
  assign push = slow_tick & data_ready & enqueue_in & ~ack
              & (~full_out | pop);

  always_comb begin
    len_next = len_out;
    case ({push, pop})
      2'b10:   len_next = len_out + 1'b1;
      2'b01:   len_next = len_out - 1'b1;
      default: len_next = len_out;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RECV;
      word       <= '0;
      bit_cnt    <= '0;
      ack        <= 1'b0;
      status_out <= 1'b1;
      data_ready <= 1'b0;
`ifdef MRDQ_PARITY_EN
      parity_err_out <= 1'b0;
`endif
    end else begin
`ifdef MRDQ_PARITY_EN
      parity_err_out <= 1'b0;
`endif
      if (push)
        ack <= 1'b1;
      if (fast_tick) begin
        case (state)
          RECV: begin
            if (write_in) begin
              word    <= {word[DATA_W-2:0], data_in};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
`ifdef MRDQ_PARITY_EN
                state <= PAR;
`else
                state      <= DONE;
                status_out <= 1'b0;
                data_ready <= 1'b1;
`endif
              end
            end
          end
`ifdef MRDQ_PARITY_EN
          PAR: begin
            if (write_in) begin
              if (data_in == ^word) begin
                state      <= DONE;
                status_out <= 1'b0;
                data_ready <= 1'b1;
              end else begin
                state          <= RECV;
                bit_cnt        <= '0;
                parity_err_out <= 1'b1;
              end
            end
          end
`endif
          DONE: begin
            if (ack) begin
              state      <= RECV;
              bit_cnt    <= '0;
              ack        <= 1'b0;
              status_out <= 1'b1;
              data_ready <= 1'b0;
            end
          end
          default: state <= RECV;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[tail] <= word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      data_out  <= '0;
      len_out   <= '0;
      full_out  <= 1'b0;
      empty_out <= 1'b1;
    end else begin
      if (push)
        tail <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
      if (pop) begin
        data_out <= mem[head];
        head     <= (head == PTR_LAST) ? '0 : head + 1'b1;
      end
      len_out   <= len_next;
      full_out  <= (len_next == LEN_FULL);
      empty_out <= (len_next == '0);
    end
  end

endmodule

// File: tb/tb_multirate_deser_queue.sv
// Directed bench for multirate_deser_queue at DATA_W=8, DEPTH=8, FAST_DIV=5, SLOW_DIV=50.
// Tick timing is tracked by counting clock edges since reset release.
module tb_multirate_deser_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       enqueue_in = 1'b0;
  logic       dequeue_in = 1'b0;
  logic       status_out;
  logic       data_ready;
  logic       full_out;
  logic       empty_out;
  logic [7:0] data_out;
  logic [3:0] len_out;
`ifdef MRDQ_PARITY_EN
  logic       parity_err_out;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  multirate_deser_queue #(
    .DATA_W(8), .DEPTH(8), .FAST_DIV(5), .SLOW_DIV(50)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .write_in(write_in),
    .status_out(status_out),
    .data_ready(data_ready),
    .enqueue_in(enqueue_in),
    .dequeue_in(dequeue_in),
    .data_out(data_out),
    .len_out(len_out),
`ifdef MRDQ_PARITY_EN
    .parity_err_out(parity_err_out),
`endif
    .full_out(full_out),
    .empty_out(empty_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_fast();
    bit t;
    do begin
      t = (cyc % 5 == 4);
      step();
    end while (!t);
  endtask

  task automatic wait_slow();
    bit t;
    do begin
      t = (cyc % 50 == 49);
      step();
    end while (!t);
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    wait_fast();
    write_in = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--)
      send_bit(w[i]);
`ifdef MRDQ_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic slow_op(input logic enq, input logic deq);
    enqueue_in = enq;
    dequeue_in = deq;
    wait_slow();
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] w);
    send_word(w);
    slow_op(1'b1, 1'b0);
    wait_fast();
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_status", status_out, 1);
    chk("rst_ready", data_ready, 0);
    chk("rst_data", data_out, 0);
    chk("rst_len", len_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    release_reset();

    send_word(8'hA5);
    chk("a5_ready", data_ready, 1);
    chk("a5_status", status_out, 0);
    slow_op(1'b1, 1'b0);
    chk("a5_len", len_out, 1);
    chk("a5_empty", empty_out, 0);
    wait_fast();
    chk("a5_status_back", status_out, 1);
    chk("a5_ready_clr", data_ready, 0);
    slow_op(1'b0, 1'b1);
    chk("a5_pop_data", data_out, 8'hA5);
    chk("a5_pop_len", len_out, 0);
    chk("a5_pop_empty", empty_out, 1);

    for (int i = 0; i < 8; i++)
      push_word(8'h10 + 8'(i));
    chk("fill_len", len_out, 8);
    chk("fill_full", full_out, 1);
    send_word(8'hEE);
    slow_op(1'b1, 1'b0);
    chk("drop_len", len_out, 8);
    chk("drop_ready", data_ready, 1);
    slow_op(1'b1, 1'b1);
    chk("full_pp_data", data_out, 8'h10);
    chk("full_pp_len", len_out, 8);
    chk("full_pp_full", full_out, 1);
    wait_fast();
    chk("full_pp_ready", data_ready, 0);
    for (int i = 0; i < 8; i++) begin
      slow_op(1'b0, 1'b1);
      chk("drain_data", data_out, (i < 7) ? 8'h11 + 8'(i) : 8'hEE);
    end
    chk("drain_empty", empty_out, 1);
    slow_op(1'b0, 1'b1);
    chk("pop_empty_data", data_out, 8'hEE);
    chk("pop_empty_len", len_out, 0);

    push_word(8'h21);
    push_word(8'h22);
    push_word(8'h23);
    chk("pp3_pre_len", len_out, 3);
    send_word(8'h24);
    slow_op(1'b1, 1'b1);
    chk("pp3_data", data_out, 8'h21);
    chk("pp3_len", len_out, 3);
    wait_fast();
    for (int i = 0; i < 3; i++) begin
      slow_op(1'b0, 1'b1);
      chk("pp3_drain", data_out, 8'h22 + 8'(i));
    end
    send_word(8'h31);
    slow_op(1'b1, 1'b1);
    chk("ppe_len", len_out, 1);
    chk("ppe_data", data_out, 8'h24);
    wait_fast();

    for (int i = 0; i < 4; i++)
      send_bit(1'b1);
    reset = 1'b1;
    #20;
    chk("mid_status", status_out, 1);
    chk("mid_ready", data_ready, 0);
    chk("mid_len", len_out, 0);
    chk("mid_data", data_out, 0);
    release_reset();
    send_word(8'h3C);
    chk("clean_ready", data_ready, 1);
    slow_op(1'b1, 1'b0);
    wait_fast();
    slow_op(1'b0, 1'b1);
    chk("clean_data", data_out, 8'h3C);
    chk("clean_len", len_out, 0);

`ifdef MRDQ_PARITY_EN
    for (int i = 7; i >= 2; i--)
      send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("par_err_pulse", parity_err_out, 1);
    chk("par_err_ready", data_ready, 0);
    chk("par_err_status", status_out, 1);
    step();
    chk("par_err_clr", parity_err_out, 0);
    send_word(8'h03);
    chk("par_ok_ready", data_ready, 1);
    chk("par_ok_err", parity_err_out, 0);
    slow_op(1'b1, 1'b0);
    chk("par_ok_len", len_out, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
